// File: rtl/bus_control_sequencer_if.sv
// Control/handshake bundle between the bus control sequencer and the datapath.
//   Inputs to the sequencer : run, IR_in[31:0], mem_ready
//   Bus-out selects          : PCout, Zhighout, Zlowout, MDRout, R2out..R7out
//   Register/unit enables    : MARin, PCin, IncPC, IRin, MDRin, Read, Yin, Zin, HIin, LOin, Rin[15:0]
//   ALU control / status     : ALU_op[4:0], busy, halted, fault
// master = sequencer side, slave = datapath side.
interface bus_control_sequencer_if;
    logic        run;
    logic [31:0] IR_in;
    logic        mem_ready;

    logic        PCout;
    logic        Zhighout;
    logic        Zlowout;
    logic        MDRout;
    logic        R2out;
    logic        R3out;
    logic        R4out;
    logic        R5out;
    logic        R6out;
    logic        R7out;

    logic        MARin;
    logic        PCin;
    logic        IncPC;
    logic        IRin;
    logic        MDRin;
    logic        Read;
    logic        Yin;
    logic        Zin;
    logic        HIin;
    logic        LOin;
    logic [15:0] Rin;
    logic [4:0]  ALU_op;

    logic        busy;
    logic        halted;
    logic        fault;

    modport master (
        input  run, IR_in, mem_ready,
        output PCout, Zhighout, Zlowout, MDRout,
        output R2out, R3out, R4out, R5out, R6out, R7out,
        output MARin, PCin, IncPC, IRin, MDRin, Read, Yin, Zin, HIin, LOin,
        output Rin, ALU_op, busy, halted, fault
    );

    modport slave (
        output run, IR_in, mem_ready,
        input  PCout, Zhighout, Zlowout, MDRout,
        input  R2out, R3out, R4out, R5out, R6out, R7out,
        input  MARin, PCin, IncPC, IRin, MDRin, Read, Yin, Zin, HIin, LOin,
        input  Rin, ALU_op, busy, halted, fault
    );
endinterface

// File: rtl/bus_control_sequencer.sv
// Control step sequencer: fetch (T0-T2) and execute (T3-T6) for a reduced ISA,
// driving the datapath bus-out selects and register enables.
//   clock     : system clock, rising edge
//   clear     : asynchronous active-low reset
//   bus       : master view of bus_control_sequencer_if (run, IR_in, mem_ready in;
//               bus-out selects, enables, Rin, ALU_op, busy/halted/fault out)
// Outputs are a Moore decode of the state register, qualified by IR fields in
// T3-T6. At most one bus-out select is active in any state.
module bus_control_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                   clock,
    input  logic                   clear,
    bus_control_sequencer_if.master bus
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_HALT  = 4'd8,
        S_FAULT = 4'd9
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // IR field extraction; low bits of IR carry no control information
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       unused_ir_c;

    assign op          = bus.IR_in[31:27];
    assign ra          = bus.IR_in[26:23];
    assign rb          = bus.IR_in[22:19];
    assign rc          = bus.IR_in[18:15];
    assign unused_ir_c = ^bus.IR_in[14:0];

    logic op_halt, op_alu, op_md, regs_ok, legal;
    assign op_halt = (op == 5'h1B);
    assign op_alu  = (op <= 5'h03);
    assign op_md   = (op == 5'h0F) || (op == 5'h10);
    assign regs_ok = (rb >= 4'd2) && (rb <= 4'd7) && (rc >= 4'd2) && (rc <= 4'd7);
    assign legal   = (op_alu || op_md) && regs_ok;

    // Timeout compare one bit wider so MEM_TIMEOUT=255 cannot wrap
    logic [CNT_W:0] cnt_inc;
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

    // Next-state and memory-wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE:  if (bus.run) state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1: begin
                if (bus.mem_ready) begin
                    state_d = S_T2;
                end else if (cnt_inc == (CNT_W+1)'(MEM_TIMEOUT)) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            S_T2:    state_d = S_T3;
            S_T3: begin
                if (op_halt)    state_d = S_HALT;
                else if (legal) state_d = S_T4;
                else            state_d = S_FAULT;
            end
            S_T4:    state_d = S_T5;
            S_T5: begin
                if (op_md)        state_d = S_T6;
                else if (bus.run) state_d = S_T0;
                else              state_d = S_IDLE;
            end
            S_T6:    state_d = bus.run ? S_T0 : S_IDLE;
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // State register; clear forces IDLE so every decoded output drops at once
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // One-hot register bus-out select, bit 0 = R2 .. bit 5 = R7
    logic [5:0] rsel;

    assign bus.R2out = rsel[0];
    assign bus.R3out = rsel[1];
    assign bus.R4out = rsel[2];
    assign bus.R5out = rsel[3];
    assign bus.R6out = rsel[4];
    assign bus.R7out = rsel[5];

    // Output decode
    always_comb begin
        rsel         = '0;
        bus.PCout    = 1'b0;
        bus.Zhighout = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.MDRout   = 1'b0;
        bus.MARin    = 1'b0;
        bus.PCin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.IRin     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.Read     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.Rin      = '0;
        bus.ALU_op   = '0;
        bus.busy     = 1'b0;
        bus.halted   = 1'b0;
        bus.fault    = 1'b0;
        case (state_q)
            S_T0: begin
                bus.busy  = 1'b1;
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            S_T1: begin
                bus.busy  = 1'b1;
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
                // Incremented PC is written back only once per fetch
                if (cnt_q == '0) begin
                    bus.Zlowout = 1'b1;
                    bus.PCin    = 1'b1;
                end
            end
            S_T2: begin
                bus.busy   = 1'b1;
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                bus.busy = 1'b1;
                // Halt and illegal encodings must not touch the bus
                if (!op_halt && legal) begin
                    rsel    = 6'((8'h01 << rb[2:0]) >> 2);
                    bus.Yin = 1'b1;
                end
            end
            S_T4: begin
                bus.busy   = 1'b1;
                rsel       = 6'((8'h01 << rc[2:0]) >> 2);
                bus.Zin    = 1'b1;
                bus.ALU_op = op;
            end
            S_T5: begin
                bus.busy    = 1'b1;
                bus.Zlowout = 1'b1;
                if (op_md) bus.LOin = 1'b1;
                else       bus.Rin  = 16'h0001 << ra;
            end
            S_T6: begin
                bus.busy     = 1'b1;
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
            end
            S_HALT:  bus.halted = 1'b1;
            S_FAULT: bus.fault  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Randomized self-checking bench for bus_control_sequencer. Each instruction is
// expanded by a reference model into a per-cycle schedule of stimulus and
// expected control vector, which is then played against the DUT.
module tb_bus_control_sequencer;

    localparam int unsigned TO = 4;

    logic clock = 1'b0;
    logic clear;

    bus_control_sequencer_if bus ();

    bus_control_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       pc_out, zh_out, zl_out, mdr_out;
        logic [7:2] r_out;
        logic       mar_in, pc_in, inc_pc, ir_ld, mdr_in, read, y_in, z_in, hi_in, lo_in;
        logic [15:0] rin;
        logic [4:0] alu_op;
        logic       busy, halted, fault;
    } ctl_t;

    typedef struct {
        logic        rdy;
        logic        run;
        logic [31:0] ir;
        ctl_t        exp;
    } cyc_t;

    cyc_t sched[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    bit   m_idle = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t obs();
        ctl_t o;
        o.pc_out  = bus.PCout;
        o.zh_out  = bus.Zhighout;
        o.zl_out  = bus.Zlowout;
        o.mdr_out = bus.MDRout;
        o.r_out   = {bus.R7out, bus.R6out, bus.R5out, bus.R4out, bus.R3out, bus.R2out};
        o.mar_in  = bus.MARin;
        o.pc_in   = bus.PCin;
        o.inc_pc  = bus.IncPC;
        o.ir_ld   = bus.IRin;
        o.mdr_in  = bus.MDRin;
        o.read    = bus.Read;
        o.y_in    = bus.Yin;
        o.z_in    = bus.Zin;
        o.hi_in   = bus.HIin;
        o.lo_in   = bus.LOin;
        o.rin     = bus.Rin;
        o.alu_op  = bus.ALU_op;
        o.busy    = bus.busy;
        o.halted  = bus.halted;
        o.fault   = bus.fault;
        return o;
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'($urandom)};
    endfunction

    task automatic push(input logic rdy, input logic run, input logic [31:0] ir, input ctl_t e);
        cyc_t c;
        c.rdy = rdy; c.run = run; c.ir = ir; c.exp = e;
        sched.push_back(c);
    endtask

    // Reference model: one instruction starting in T0.
    // kind: 0 = continues to T0, 1 = returns to IDLE, 2 = FAULT, 3 = HALT.
    task automatic build_instr(input logic [31:0] ir, input int d, input bit run_end,
                               output int kind);
        ctl_t e;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit legal, md;
        op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        md    = (op == 5'h0F) || (op == 5'h10);
        legal = ((op <= 5'h03) || md) && rb >= 2 && rb <= 7 && rc >= 2 && rc <= 7;

        e = '0; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1; e.busy = 1;
        push(1'($urandom), 1'($urandom), $urandom, e);

        for (int k = 0; ; k++) begin
            e = '0; e.read = 1; e.mdr_in = 1; e.busy = 1;
            if (k == 0) begin e.zl_out = 1; e.pc_in = 1; end
            if (k == d) begin
                push(1'b1, 1'($urandom), $urandom, e);
                break;
            end
            push(1'b0, 1'($urandom), $urandom, e);
            if (k + 1 == int'(TO)) begin kind = 2; return; end
        end

        e = '0; e.mdr_out = 1; e.ir_ld = 1; e.busy = 1;
        push(1'($urandom), 1'($urandom), $urandom, e);

        e = '0; e.busy = 1;
        if (op == 5'h1B) begin
            push(1'($urandom), 1'($urandom), ir, e);
            kind = 3; return;
        end
        if (!legal) begin
            push(1'($urandom), 1'($urandom), ir, e);
            kind = 2; return;
        end
        e.r_out[rb] = 1; e.y_in = 1;
        push(1'($urandom), 1'($urandom), ir, e);

        e = '0; e.busy = 1; e.r_out[rc] = 1; e.z_in = 1; e.alu_op = op;
        push(1'($urandom), 1'($urandom), ir, e);

        e = '0; e.busy = 1; e.zl_out = 1;
        if (md) begin
            e.lo_in = 1;
            push(1'($urandom), 1'($urandom), ir, e);
            e = '0; e.busy = 1; e.zh_out = 1; e.hi_in = 1;
            push(1'($urandom), run_end, ir, e);
        end else begin
            e.rin[ra] = 1;
            push(1'($urandom), run_end, ir, e);
        end
        kind = run_end ? 0 : 1;
    endtask

    task automatic drive(input cyc_t c);
        bus.run       = c.run;
        bus.mem_ready = c.rdy;
        bus.IR_in     = c.ir;
    endtask

    task automatic check_now(input ctl_t e);
        ctl_t o;
        o = obs();
        chk($sformatf("cyc%0d_ctl", cycle), 64'(o), 64'(e));
        chk($sformatf("cyc%0d_bus1hot", cycle),
            64'($countones({o.pc_out, o.zh_out, o.zl_out, o.mdr_out, o.r_out}) <= 1), 64'(1));
        chk($sformatf("cyc%0d_rin1hot", cycle), 64'($onehot0(o.rin)), 64'(1));
    endtask

    // Play up to n scheduled cycles; entered and left at posedge+1
    task automatic play(input int n);
        cyc_t c;
        for (int i = 0; i < n && sched.size() > 0; i++) begin
            c = sched.pop_front();
            drive(c);
            @(negedge clock);
            check_now(c.exp);
            cycle++;
            @(posedge clock);
            #1;
        end
    endtask

    // Asynchronous clear pulse mid-cycle; outputs must drop without a clock edge
    task automatic reset_pulse();
        #2;
        bus.run = 1'b0;
        clear   = 1'b0;
        #1;
        chk("rst_async", 64'(obs()), 64'(0));
        @(posedge clock);
        #1;
        chk("rst_hold", 64'(obs()), 64'(0));
        clear = 1'b1;
        @(posedge clock);
        #1;
        m_idle = 1'b1;
    endtask

    task automatic run_instr(input logic [31:0] ir, input int d, input bit run_end);
        int   kind;
        ctl_t e;
        if (m_idle) begin
            e = '0;
            if ($urandom_range(0, 2) == 0) push(1'($urandom), 1'b0, $urandom, e);
            push(1'($urandom), 1'b1, $urandom, e);
        end
        build_instr(ir, d, run_end, kind);
        if (kind >= 2) begin
            e = '0;
            if (kind == 2) e.fault = 1; else e.halted = 1;
            repeat (3) push(1'($urandom), 1'($urandom), $urandom, e);
            play(1000);
            reset_pulse();
        end else begin
            play(1000);
            m_idle = (kind == 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    logic [4:0] legal_ops [6] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h0F, 5'h10};

    initial begin
        int   kind, r, d;
        cyc_t c;
        ctl_t e;
        logic [31:0] ir;

        clear = 1'b0; bus.run = 1'b0; bus.mem_ready = 1'b0; bus.IR_in = '0;
        #1;
        chk("reset_state", 64'(obs()), 64'(0));
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b1;
        @(posedge clock);
        #1;
        chk("idle_after_reset", 64'(obs()), 64'(0));

        // Clear in the middle of T4 aborts the instruction
        e = '0;
        push(1'b0, 1'b1, '0, e);
        build_instr(mk_ir(5'h00, 4'd4, 4'd2, 4'd3), 0, 1'b1, kind);
        play(5);
        c = sched.pop_front();
        drive(c);
        #1;
        chk("t4_before_clear", 64'(obs()), 64'(c.exp));
        reset_pulse();
        sched.delete();

        run_instr(mk_ir(5'h00, 4'd4, 4'd2, 4'd3), 0, 1'b1);
        run_instr(mk_ir(5'h00, 4'd4, 4'd2, 4'd3), 3, 1'b1);
        run_instr(mk_ir(5'h0F, 4'd5, 4'd6, 4'd7), 0, 1'b1);
        run_instr(mk_ir(5'h10, 4'd1, 4'd7, 4'd2), 1, 1'b1);
        run_instr(mk_ir(5'h01, 4'd15, 4'd3, 4'd5), 2, 1'b0);
        run_instr(mk_ir(5'h02, 4'd0, 4'd9, 4'd3), 0, 1'b1);
        run_instr(mk_ir(5'h03, 4'd2, 4'd2, 4'd7), 10, 1'b1);
        run_instr(mk_ir(5'h1B, 4'd0, 4'd0, 4'd0), 0, 1'b1);
        run_instr(mk_ir(5'h0F, 4'd3, 4'd2, 4'd1), 0, 1'b1);
        run_instr(mk_ir(5'h04, 4'd3, 4'd2, 4'd2), 0, 1'b1);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            if (r == 0)      ir = mk_ir(5'h1B, 4'($urandom), 4'($urandom), 4'($urandom));
            else if (r == 1) ir = mk_ir(5'($urandom), 4'($urandom), 4'($urandom_range(2, 7)), 4'($urandom_range(2, 7)));
            else if (r == 2) ir = mk_ir(legal_ops[$urandom_range(0, 5)], 4'($urandom), 4'($urandom), 4'($urandom));
            else             ir = mk_ir(legal_ops[$urandom_range(0, 5)], 4'($urandom),
                                        4'($urandom_range(2, 7)), 4'($urandom_range(2, 7)));
            run_instr(ir, d, 1'($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
